// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants for the jump target unit and its sub-blocks.
// Holds opcode/funct values, the return-address register number, the field
// widths of the instruction word and the J/JAL region-relative target helper.
package mips_pkg;

  localparam int OP_W  = 6;
  localparam int FN_W  = 6;
  localparam int REG_W = 5;
  localparam int IDX_W = 26;

  localparam logic [OP_W-1:0]  OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0]  OP_J     = 6'h02;
  localparam logic [OP_W-1:0]  OP_JAL   = 6'h03;

  localparam logic [FN_W-1:0]  FN_JR    = 6'h08;
  localparam logic [FN_W-1:0]  FN_JALR  = 6'h09;

  localparam logic [REG_W-1:0] REG_RA   = 5'd31;

  // J/JAL keep the 256 MB region of the delay-slot address and splice in the
  // word-aligned 26-bit index.
  function automatic logic [31:0] region_target(input logic [31:0]      pc_plus_4,
                                                input logic [IDX_W-1:0] index);
    return {pc_plus_4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack built as a circular buffer.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointer/count only)
//   push, pop     : push_data is pushed; both together replace the top entry
//   push_data     : address to store
//   top           : current top entry, 0 when empty
//   count         : number of valid entries, saturates at RAS_DEPTH
module ras_stack #(
  parameter int RAS_DEPTH = 8,
  parameter int PTR_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      push_data,
  output logic [31:0]      top,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

  logic [31:0]      mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;      // next free slot; wraps, so a push when full overwrites the oldest
  logic [PTR_W-1:0] top_idx;
  logic             empty;

  assign empty   = (count == '0);
  assign top_idx = ptr - 1'b1;
  assign top     = empty ? 32'h0 : mem[top_idx];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      if (pop && !empty) mem[top_idx] <= push_data;
      else               mem[ptr]     <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop) begin
      // Replace in place; on an empty stack this degenerates to a plain push.
      if (empty) begin
        ptr   <= ptr + 1'b1;
        count <= (PTR_W+1)'(1);
      end
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (count != FULL) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/jump_target_unit.sv
// Jump decode for the single-cycle datapath: produces the PC-mux jump target
// and select, the JAL/JALR link write, and a return-address stack that checks
// every JR $31 against the register value (checking only, never redirects).
// Ports:
//   Clk, Reset        : clock, synchronous active-high reset
//   Instr_Valid       : Instruction is real (not a bubble)
//   Instruction       : current instruction word
//   PC_Plus_4         : next sequential address, also the link value
//   Reg_Rs_Data       : register-file read of rs
//   Jump_Instruction  : jump target to the PC mux (0 when not jumping)
//   Jump_Control      : PC mux selects Jump_Instruction
//   Link_Write/Reg/Address : register-file link write for JAL/JALR
//   Ras_Top, Ras_Count: RAS top entry (0 when empty) and occupancy
//   Ras_Mismatch      : one-cycle pulse after a JR $31 whose target differed from Ras_Top
//   Ras_Underflow     : one-cycle pulse after a JR $31 on an empty RAS
//   Jump_Count        : taken jumps since reset, wrapping
module jump_target_unit
  import mips_pkg::*;
#(
  parameter int RAS_DEPTH = 8,
  parameter int PTR_W     = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Instr_Valid,
  input  logic [31:0]      Instruction,
  input  logic [31:0]      PC_Plus_4,
  input  logic [31:0]      Reg_Rs_Data,
  output logic [31:0]      Jump_Instruction,
  output logic             Jump_Control,
  output logic             Link_Write,
  output logic [4:0]       Link_Reg,
  output logic [31:0]      Link_Address,
  output logic [31:0]      Ras_Top,
  output logic [PTR_W:0]   Ras_Count,
  output logic             Ras_Mismatch,
  output logic             Ras_Underflow,
  output logic [31:0]      Jump_Count
);

  logic [OP_W-1:0]  op;
  logic [FN_W-1:0]  funct;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rd;
  logic             is_j, is_jal, is_jr, is_jalr, is_jump;
  logic             active;
  logic             ras_push, ras_pop, ras_empty;

  assign op    = Instruction[31:26];
  assign rs    = Instruction[25:21];
  assign rd    = Instruction[15:11];
  assign funct = Instruction[5:0];

  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);
  assign is_jr   = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_jalr = (op == OP_RTYPE) && (funct == FN_JALR);
  assign is_jump = is_j | is_jal | is_jr | is_jalr;

  // Every side effect is qualified by a real instruction outside reset.
  assign active = Instr_Valid & ~Reset;

  always_comb begin
    Jump_Instruction = 32'h0;
    Link_Reg         = 5'd0;
    if (active) begin
      if (is_j || is_jal)        Jump_Instruction = region_target(PC_Plus_4, Instruction[IDX_W-1:0]);
      else if (is_jr || is_jalr) Jump_Instruction = Reg_Rs_Data;
      if (is_jal)       Link_Reg = REG_RA;
      else if (is_jalr) Link_Reg = rd;
    end
  end

  assign Jump_Control = active & is_jump;
  assign Link_Write   = active & (is_jal | is_jalr);
  assign Link_Address = PC_Plus_4;

  assign ras_push  = active & (is_jal | is_jalr);
  assign ras_pop   = active & (is_jr | is_jalr) & (rs == REG_RA);
  assign ras_empty = (Ras_Count == '0);

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PTR_W     (PTR_W)
  ) u_ras (
    .clk       (Clk),
    .rst       (Reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (PC_Plus_4),
    .top       (Ras_Top),
    .count     (Ras_Count)
  );

  // Check results are registered so they report the previous cycle's JR $31.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Ras_Mismatch  <= 1'b0;
      Ras_Underflow <= 1'b0;
      Jump_Count    <= 32'h0;
    end else begin
      Ras_Underflow <= ras_pop & ras_empty;
      Ras_Mismatch  <= ras_pop & ~ras_empty & (Ras_Top != Reg_Rs_Data);
      if (Jump_Control) Jump_Count <= Jump_Count + 32'd1;
    end
  end

endmodule

// File: tb/tb_jump_target_unit.sv
module tb_jump_target_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Instr_Valid;
  logic [31:0] Instruction;
  logic [31:0] PC_Plus_4;
  logic [31:0] Reg_Rs_Data;
  logic [31:0] Jump_Instruction;
  logic        Jump_Control;
  logic        Link_Write;
  logic [4:0]  Link_Reg;
  logic [31:0] Link_Address;
  logic [31:0] Ras_Top;
  logic [3:0]  Ras_Count;
  logic        Ras_Mismatch;
  logic        Ras_Underflow;
  logic [31:0] Jump_Count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_JR31 = 32'h03E0_0008;  // jr $31
  localparam logic [31:0] I_JR5  = 32'h00A0_0008;  // jr $5
  localparam logic [31:0] I_JAL  = 32'h0C00_0100;  // jal index 0x100
  localparam logic [31:0] I_JALR = 32'h03E0_2809;  // jalr $5, $31
  localparam logic [31:0] I_ADD  = 32'h0000_0020;  // add, not a jump

  jump_target_unit #(.RAS_DEPTH(8), .PTR_W(3)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Instr_Valid      (Instr_Valid),
    .Instruction      (Instruction),
    .PC_Plus_4        (PC_Plus_4),
    .Reg_Rs_Data      (Reg_Rs_Data),
    .Jump_Instruction (Jump_Instruction),
    .Jump_Control     (Jump_Control),
    .Link_Write       (Link_Write),
    .Link_Reg         (Link_Reg),
    .Link_Address     (Link_Address),
    .Ras_Top          (Ras_Top),
    .Ras_Count        (Ras_Count),
    .Ras_Mismatch     (Ras_Mismatch),
    .Ras_Underflow    (Ras_Underflow),
    .Jump_Count       (Jump_Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a new input set and let combinational outputs settle away from the edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc4,
                       input logic [31:0] rsd);
    Instr_Valid = v;
    Instruction = ins;
    PC_Plus_4   = pc4;
    Reg_Rs_Data = rsd;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    // Reset high with a valid JAL presented: only Link_Address may be non-zero.
    drive(1'b1, I_JAL, 32'h0000_1234, 32'h0);
    chk("rst_jc", {31'd0, Jump_Control}, 32'd0);
    chk("rst_lw", {31'd0, Link_Write}, 32'd0);
    chk("rst_ji", Jump_Instruction, 32'h0);
    chk("rst_lr", {27'd0, Link_Reg}, 32'd0);
    chk("rst_la", Link_Address, 32'h0000_1234);
    tick(); tick();
    Reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk("rst_cnt", {28'd0, Ras_Count}, 32'd0);
    chk("rst_top", Ras_Top, 32'h0);
    chk("rst_jcount", Jump_Count, 32'd0);
    chk("rst_mis", {31'd0, Ras_Mismatch}, 32'd0);
    chk("rst_unf", {31'd0, Ras_Underflow}, 32'd0);

    // J: index 0x0800010 -> 0x0200_0040
    drive(1'b1, 32'h0880_0010, 32'h0040_0004, 32'h0);
    chk("j_jc", {31'd0, Jump_Control}, 32'd1);
    chk("j_ji", Jump_Instruction, 32'h0200_0040);
    chk("j_lw", {31'd0, Link_Write}, 32'd0);
    tick();
    chk("j_count", Jump_Count, 32'd1);

    // J keeps the upper nibble of PC_Plus_4
    drive(1'b1, 32'h0800_0001, 32'hA000_0004, 32'h0);
    chk("j_region", Jump_Instruction, 32'hA000_0004);
    tick();

    // JAL then matching JR $31
    drive(1'b1, I_JAL, 32'h0040_0100, 32'h0);
    chk("jal_ji", Jump_Instruction, 32'h0000_0400);
    chk("jal_lw", {31'd0, Link_Write}, 32'd1);
    chk("jal_lr", {27'd0, Link_Reg}, 32'd31);
    chk("jal_la", Link_Address, 32'h0040_0100);
    tick();
    chk("jal_cnt", {28'd0, Ras_Count}, 32'd1);
    chk("jal_top", Ras_Top, 32'h0040_0100);
    chk("jal_count", Jump_Count, 32'd3);
    drive(1'b1, I_JR31, 32'h0040_0204, 32'h0040_0100);
    chk("jr_ji", Jump_Instruction, 32'h0040_0100);
    chk("jr_jc", {31'd0, Jump_Control}, 32'd1);
    chk("jr_lw", {31'd0, Link_Write}, 32'd0);
    tick();
    chk("jr_mis", {31'd0, Ras_Mismatch}, 32'd0);
    chk("jr_unf", {31'd0, Ras_Underflow}, 32'd0);
    chk("jr_cnt", {28'd0, Ras_Count}, 32'd0);

    // Mismatching JR $31
    drive(1'b1, I_JAL, 32'h0040_0100, 32'h0);
    tick();
    drive(1'b1, I_JR31, 32'h0040_0304, 32'h0000_1234);
    chk("mis_ji", Jump_Instruction, 32'h0000_1234);
    tick();
    chk("mis_pulse", {31'd0, Ras_Mismatch}, 32'd1);
    chk("mis_cnt", {28'd0, Ras_Count}, 32'd0);
    chk("mis_count", Jump_Count, 32'd6);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("mis_clear", {31'd0, Ras_Mismatch}, 32'd0);

    // Underflow on empty RAS, then JR $5 which is not a return
    drive(1'b1, I_JR31, 32'h0040_0404, 32'h0000_0800);
    tick();
    chk("unf_pulse", {31'd0, Ras_Underflow}, 32'd1);
    chk("unf_mis", {31'd0, Ras_Mismatch}, 32'd0);
    chk("unf_cnt", {28'd0, Ras_Count}, 32'd0);
    drive(1'b1, I_JR5, 32'h0040_0408, 32'h0000_0900);
    chk("jr5_jc", {31'd0, Jump_Control}, 32'd1);
    chk("jr5_ji", Jump_Instruction, 32'h0000_0900);
    tick();
    chk("jr5_unf", {31'd0, Ras_Underflow}, 32'd0);
    chk("jr5_count", Jump_Count, 32'd8);

    // Bubble and non-jump: nothing asserted, no state change
    drive(1'b0, I_JAL, 32'h0040_0500, 32'h0);
    chk("inv_jc", {31'd0, Jump_Control}, 32'd0);
    chk("inv_lw", {31'd0, Link_Write}, 32'd0);
    tick();
    chk("inv_cnt", {28'd0, Ras_Count}, 32'd0);
    drive(1'b1, I_ADD, 32'h0040_0504, 32'h0000_7777);
    chk("add_jc", {31'd0, Jump_Control}, 32'd0);
    chk("add_ji", Jump_Instruction, 32'h0);
    tick();
    chk("add_count", Jump_Count, 32'd8);

    // JALR $5,$31 on empty RAS: underflow, acts as push
    drive(1'b1, I_JALR, 32'h0000_2004, 32'h0000_5000);
    chk("jalr_ji", Jump_Instruction, 32'h0000_5000);
    chk("jalr_lw", {31'd0, Link_Write}, 32'd1);
    chk("jalr_lr", {27'd0, Link_Reg}, 32'd5);
    tick();
    chk("jalr_unf", {31'd0, Ras_Underflow}, 32'd1);
    chk("jalr_cnt", {28'd0, Ras_Count}, 32'd1);
    chk("jalr_top", Ras_Top, 32'h0000_2004);
    // JAL then JALR replace with a matching register
    drive(1'b1, I_JAL, 32'h0000_3004, 32'h0);
    tick();
    drive(1'b1, I_JALR, 32'h0000_4008, 32'h0000_3004);
    tick();
    chk("repl_mis", {31'd0, Ras_Mismatch}, 32'd0);
    chk("repl_cnt", {28'd0, Ras_Count}, 32'd2);
    chk("repl_top", Ras_Top, 32'h0000_4008);
    chk("repl_count", Jump_Count, 32'd11);

    // Reset, then overflow: 9 pushes into 8 entries
    Reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    Reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, I_JAL, 32'h0000_1000 * k, 32'h0);
      tick();
    end
    chk("full_cnt", {28'd0, Ras_Count}, 32'd8);
    chk("full_top", Ras_Top, 32'h0000_9000);
    for (int j = 1; j <= 8; j++) begin
      drive(1'b1, I_JR31, 32'h0, 32'h0000_1000 * (10 - j));
      chk($sformatf("pop%0d_top", j), Ras_Top, 32'h0000_1000 * (10 - j));
      tick();
      chk($sformatf("pop%0d_mis", j), {31'd0, Ras_Mismatch}, 32'd0);
    end
    chk("drain_cnt", {28'd0, Ras_Count}, 32'd0);
    chk("drain_count", Jump_Count, 32'd17);

    // Mid-stream reset after 3 pushes and 5 jumps
    Reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    Reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, I_JAL, 32'h0000_0100 * k, 32'h0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h0800_0001, 32'h0000_0004, 32'h0);
      tick();
    end
    chk("mid_cnt", {28'd0, Ras_Count}, 32'd3);
    chk("mid_count", Jump_Count, 32'd5);
    Reset = 1'b1;
    drive(1'b1, 32'h0800_0001, 32'h0000_0004, 32'h0);
    chk("mid_rst_jc", {31'd0, Jump_Control}, 32'd0);
    tick();
    chk("mid_rst_cnt", {28'd0, Ras_Count}, 32'd0);
    chk("mid_rst_top", Ras_Top, 32'h0);
    chk("mid_rst_count", Jump_Count, 32'd0);
    chk("mid_rst_jc2", {31'd0, Jump_Control}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
